imm_encoder: RTL and testbench

- Instruction-word encoder: the inverse of the core's immediate decoder.
- Takes decoded fields (type, subtype, register indices, funct fields, 32-bit sign-extended immediate) and packs them into a 32-bit RV32I instruction word.
- Two-stage valid/ready pipeline. Each output word is tagged with an auto-incrementing instruction-memory byte address.
- Sits between the test/boot-loader stream and instruction-memory write port; the bench also uses it for decoder round-trip checks.

---
 rtl/imm_encoder_pkg.sv | 56 +++++
 rtl/imm_encoder_imm_field_pack.sv | 68 ++++++
 rtl/imm_encoder.sv | 157 +++++++++++++++
 tb/tb_imm_encoder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_encoder_pkg
// Shared control type definitions (instruction type / subtype enums) plus the
// RV32I field bit positions and a format-selection helper used by the
// instruction-word encoder.
// -----------------------------------------------------------------------------
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    REG_COMPUTATION = 3'd0,
    IMM_COMPUTATION = 3'd1,
    LOAD            = 3'd2,
    STORE           = 3'd3,
    BRANCH          = 3'd4,
    JUMP            = 3'd5,
    UPPER           = 3'd6
  } InstructionTypes;

  typedef enum logic [1:0] {
    SUB_NONE      = 2'd0,
    JUMP_LINK     = 2'd1,
    JUMP_LINK_REG = 2'd2
  } InstructionSubTypes;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  // JALR shares the I layout; every other JUMP is the J layout.
  function automatic imm_fmt_e get_fmt(input InstructionTypes t,
                                       input InstructionSubTypes s);
    imm_fmt_e f;
    case (t)
      IMM_COMPUTATION, LOAD: f = FMT_I;
      STORE:                 f = FMT_S;
      BRANCH:                f = FMT_B;
      UPPER:                 f = FMT_U;
      JUMP:                  f = (s == JUMP_LINK_REG) ? FMT_I : FMT_J;
      default:               f = FMT_R;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_encoder_imm_field_pack.sv
// -----------------------------------------------------------------------------
// imm_field_pack
// Combinational scatter of a 32-bit sign-extended immediate into its RV32I
// instruction-word bit positions, plus a "not representable" flag.
// Optional: IMM_RANGE_CHECK_EN enables the range/alignment check; without it
// o_error is tied low.
// Ports:
//   i_type, i_subtype : select encoding format
//   i_imm             : sign-extended immediate (byte offset for B/J)
//   o_imm_bits        : word with only the immediate bits populated
//   o_error           : immediate does not fit the selected format
// -----------------------------------------------------------------------------
module imm_field_pack
  import imm_encoder_pkg::*;
(
  input  InstructionTypes    i_type,
  input  InstructionSubTypes i_subtype,
  input  logic [31:0]        i_imm,
  output logic [31:0]        o_imm_bits,
  output logic               o_error
);

  imm_fmt_e w_fmt;

  assign w_fmt = get_fmt(i_type, i_subtype);

  always_comb begin
    o_imm_bits = '0;
    case (w_fmt)
      FMT_I: o_imm_bits[31:20] = i_imm[11:0];
      FMT_S: begin
        o_imm_bits[31:25] = i_imm[11:5];
        o_imm_bits[11:7]  = i_imm[4:0];
      end
      FMT_B: begin
        o_imm_bits[31]    = i_imm[12];
        o_imm_bits[30:25] = i_imm[10:5];
        o_imm_bits[11:8]  = i_imm[4:1];
        o_imm_bits[7]     = i_imm[11];
      end
      FMT_U: o_imm_bits[31:12] = i_imm[31:12];
      FMT_J: begin
        o_imm_bits[31]    = i_imm[20];
        o_imm_bits[30:21] = i_imm[10:1];
        o_imm_bits[20]    = i_imm[11];
        o_imm_bits[19:12] = i_imm[19:12];
      end
      default: ;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // The dropped upper bits must all equal the retained sign bit.
  always_comb begin
    o_error = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S: o_error = !((&i_imm[31:11]) || !(|i_imm[31:11]));
      FMT_B: o_error = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
      FMT_J: o_error = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
      FMT_U: o_error = |i_imm[11:0];
      default: o_error = 1'b0;
    endcase
  end
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Packs decoded instruction fields into a 32-bit RV32I word through a two-stage
// valid/ready pipeline and tags each word with an auto-incrementing byte
// address (BASE_ADDR after reset/flush, +4 per output handshake).
// Optional: IMM_RANGE_CHECK_EN enables oError (immediate not representable).
// Ports:
//   iClk, iRst (async, active-high), iFlush (sync pipeline drop)
//   iValid/oReady                   : request handshake
//   iInstructionType/SubType        : encoding format select
//   iOpcode, iFunct3, iFunct7, iRd, iRs1, iRs2, iImm : instruction fields
//   oValid/iReady                   : output handshake
//   oInstruction, oAddr, oError     : encoded word, its address, range flag
// oReady depends combinationally on iReady.
// -----------------------------------------------------------------------------
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iFlush,
  input  logic                  iValid,
  output logic                  oReady,
  input  InstructionTypes       iInstructionType,
  input  InstructionSubTypes    iInstructionSubType,
  input  logic [6:0]            iOpcode,
  input  logic [2:0]            iFunct3,
  input  logic [6:0]            iFunct7,
  input  logic [4:0]            iRd,
  input  logic [4:0]            iRs1,
  input  logic [4:0]            iRs2,
  input  logic [31:0]           iImm,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [31:0]           oInstruction,
  output logic [ADDR_WIDTH-1:0] oAddr,
  output logic                  oError
);

  logic                  r_vld_p1;
  InstructionTypes       r_type_p1;
  InstructionSubTypes    r_sub_p1;
  logic [6:0]            r_opcode_p1;
  logic [2:0]            r_funct3_p1;
  logic [6:0]            r_funct7_p1;
  logic [4:0]            r_rd_p1;
  logic [4:0]            r_rs1_p1;
  logic [4:0]            r_rs2_p1;
  logic [31:0]           r_imm_p1;

  logic                  r_vld_p2;
  logic [31:0]           r_instr_p2;
  logic                  r_err_p2;
  logic [ADDR_WIDTH-1:0] r_addr_p2;

  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_s2_load;
  imm_fmt_e              w_fmt;
  logic [31:0]           w_imm_bits;
  logic                  w_imm_err;
  logic [31:0]           w_word;

  assign w_out_hs  = r_vld_p2 && iReady;
  assign w_s2_load = r_vld_p1 && (!r_vld_p2 || iReady);
  assign oReady    = !r_vld_p1 || w_s2_load;
  assign w_in_hs   = iValid && oReady;

  // ---- stage 1: capture request fields ----
  always_ff @(posedge iClk) begin
    if (w_in_hs) begin
      r_type_p1   <= iInstructionType;
      r_sub_p1    <= iInstructionSubType;
      r_opcode_p1 <= iOpcode;
      r_funct3_p1 <= iFunct3;
      r_funct7_p1 <= iFunct7;
      r_rd_p1     <= iRd;
      r_rs1_p1    <= iRs1;
      r_rs2_p1    <= iRs2;
      r_imm_p1    <= iImm;
    end
  end

  // ---- stage 2: encode and hold word/address/error ----
  imm_field_pack u_imm_field_pack (
    .i_type     (r_type_p1),
    .i_subtype  (r_sub_p1),
    .i_imm      (r_imm_p1),
    .o_imm_bits (w_imm_bits),
    .o_error    (w_imm_err)
  );

  assign w_fmt = get_fmt(r_type_p1, r_sub_p1);

  // Only the register fields that belong to the format are placed.
  always_comb begin
    w_word = '0;
    w_word[OPCODE_LSB +: 7] = r_opcode_p1;
    case (w_fmt)
      FMT_I: begin
        w_word[RD_LSB +: 5]     = r_rd_p1;
        w_word[FUNCT3_LSB +: 3] = r_funct3_p1;
        w_word[RS1_LSB +: 5]    = r_rs1_p1;
      end
      FMT_S, FMT_B: begin
        w_word[FUNCT3_LSB +: 3] = r_funct3_p1;
        w_word[RS1_LSB +: 5]    = r_rs1_p1;
        w_word[RS2_LSB +: 5]    = r_rs2_p1;
      end
      FMT_U, FMT_J: w_word[RD_LSB +: 5] = r_rd_p1;
      default: begin
        w_word[RD_LSB +: 5]     = r_rd_p1;
        w_word[FUNCT3_LSB +: 3] = r_funct3_p1;
        w_word[RS1_LSB +: 5]    = r_rs1_p1;
        w_word[RS2_LSB +: 5]    = r_rs2_p1;
        w_word[FUNCT7_LSB +: 7] = r_funct7_p1;
      end
    endcase
    w_word = w_word | w_imm_bits;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_instr_p2 <= '0;
      r_err_p2   <= 1'b0;
      r_addr_p2  <= BASE_ADDR;
    end else if (iFlush) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_addr_p2 <= BASE_ADDR;
    end else begin
      if (w_in_hs)        r_vld_p1 <= 1'b1;
      else if (w_s2_load) r_vld_p1 <= 1'b0;

      if (w_s2_load) begin
        r_vld_p2   <= 1'b1;
        r_instr_p2 <= w_word;
        r_err_p2   <= w_imm_err;
      end else if (w_out_hs) begin
        r_vld_p2 <= 1'b0;
      end

      if (w_out_hs) r_addr_p2 <= r_addr_p2 + ADDR_WIDTH'(4);
    end
  end

  assign oValid       = r_vld_p2;
  assign oInstruction = r_instr_p2;
  assign oAddr        = r_addr_p2;
  assign oError       = r_err_p2;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;
  import imm_encoder_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic               iClk = 1'b0;
  logic               iRst = 1'b1;
  logic               iFlush = 1'b0;
  logic               iValid = 1'b0;
  logic               oReady;
  InstructionTypes    iInstructionType = REG_COMPUTATION;
  InstructionSubTypes iInstructionSubType = SUB_NONE;
  logic [6:0]         iOpcode = '0;
  logic [2:0]         iFunct3 = '0;
  logic [6:0]         iFunct7 = '0;
  logic [4:0]         iRd = '0, iRs1 = '0, iRs2 = '0;
  logic [31:0]        iImm = '0;
  logic               oValid;
  logic               iReady = 1'b0;
  logic [31:0]        oInstruction;
  logic [31:0]        oAddr;
  logic               oError;

  int n_vec = 0;
  int n_err = 0;

  imm_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
    .iClk(iClk), .iRst(iRst), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
    .iInstructionType(iInstructionType), .iInstructionSubType(iInstructionSubType),
    .iOpcode(iOpcode), .iFunct3(iFunct3), .iFunct7(iFunct7),
    .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm),
    .oValid(oValid), .iReady(iReady), .oInstruction(oInstruction),
    .oAddr(oAddr), .oError(oError)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    InstructionTypes    t;
    InstructionSubTypes s;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    bit          err;
  } vec_t;

  typedef struct {
    InstructionTypes    t;
    InstructionSubTypes s;
    logic [6:0]  opc;
    logic [31:0] imm;
    logic [31:0] addr;
  } rec_t;

  task automatic set_req(input InstructionTypes t, input InstructionSubTypes s,
                         input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    iInstructionType = t; iInstructionSubType = s; iOpcode = opc;
    iFunct3 = f3; iFunct7 = f7; iRd = rd; iRs1 = rs1; iRs2 = rs2; iImm = imm;
    iValid = 1'b1;
  endtask

  // Holds the request until accepted; returns at the negedge after the accepting edge.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (oReady) begin
        @(posedge iClk); @(negedge iClk);
        ok = 1'b1;
        return;
      end
      @(negedge iClk);
    end
  endtask

  task automatic wait_ovalid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (oValid) begin ok = 1'b1; return; end
      @(negedge iClk);
    end
  endtask

  task automatic do_reset();
    iRst = 1'b1; iValid = 1'b0; iFlush = 1'b0; iReady = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
  endtask

  function automatic logic [31:0] dec_imm(input InstructionTypes t, input InstructionSubTypes s,
                                          input logic [31:0] w);
    case (t)
      IMM_COMPUTATION, LOAD: return {{20{w[31]}}, w[31:20]};
      STORE:  return {{20{w[31]}}, w[31:25], w[11:7]};
      BRANCH: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      UPPER:  return {w[31:12], 12'b0};
      JUMP:   if (s == JUMP_LINK_REG) return {{20{w[31]}}, w[31:20]};
              else return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    bit ok;
    @(negedge iClk); #1;
    n_vec++;
    if (oValid !== 1'b0 || oInstruction !== 32'h0 || oAddr !== 32'h0 || oError !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: oValid=%b oInstruction=%h oAddr=%h oError=%b, want 0/0/0/0",
               oValid, oInstruction, oAddr, oError);
    end
    iRst = 1'b0;
    @(negedge iClk);
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    wait_accept(ok);
    iValid = 1'b0;
    @(negedge iClk);
    iRst = 1'b1; #1;
    n_vec++;
    if (oValid !== 1'b0 || oInstruction !== 32'h0 || oAddr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_midflight: oValid=%b oInstruction=%h oAddr=%h, want 0/0/0",
               oValid, oInstruction, oAddr);
    end
    @(negedge iClk);
    iRst = 1'b0; iReady = 1'b1;
    repeat (3) @(negedge iClk);
    n_vec++;
    if (oValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard: oValid=%b, want 0", oValid);
    end
  endtask

  task automatic test_addi_latency();
    bit ok;
    do_reset();
    iReady = 1'b1;
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    wait_accept(ok);
    iValid = 1'b0;
    n_vec++;
    if (!ok || oValid !== 1'b0) begin
      n_err++;
      $display("FAIL addi_stage1: accepted=%b oValid=%b, want 1/0", ok, oValid);
    end
    @(negedge iClk);
    n_vec++;
    if (oValid !== 1'b1 || oInstruction !== 32'hFFF0_0093 || oAddr !== 32'h0 || oError !== 1'b0) begin
      n_err++;
      $display("FAIL addi_word: oValid=%b word=%h addr=%h err=%b, want 1/fff00093/0/0",
               oValid, oInstruction, oAddr, oError);
    end
  endtask

  task automatic test_formats();
    vec_t v[11];
    bit ok;
    v[0]  = '{LOAD,            SUB_NONE,      7'h03, 3'd2, 7'h7F, 5'd6,  5'd2,  5'd9,  32'hFFFF_FFFC, 32'hFFC1_2303, 1'b0};
    v[1]  = '{STORE,           SUB_NONE,      7'h23, 3'd2, 7'h7F, 5'd31, 5'd1,  5'd2,  32'd12,        32'h0020_A623, 1'b0};
    v[2]  = '{UPPER,           SUB_NONE,      7'h37, 3'd7, 7'h7F, 5'd5,  5'd31, 5'd31, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    v[3]  = '{JUMP,            JUMP_LINK_REG, 7'h67, 3'd0, 7'h7F, 5'd1,  5'd5,  5'd31, 32'd4,         32'h0042_80E7, 1'b0};
    v[4]  = '{REG_COMPUTATION, SUB_NONE,      7'h33, 3'd0, 7'h20, 5'd3,  5'd1,  5'd2,  32'hFFFF_FFFF, 32'h4020_81B3, 1'b0};
    v[5]  = '{IMM_COMPUTATION, SUB_NONE,      7'h13, 3'd0, 7'd0,  5'd1,  5'd0,  5'd0,  32'hFFFF_F800, 32'h8000_0093, 1'b0};
    v[6]  = '{IMM_COMPUTATION, SUB_NONE,      7'h13, 3'd0, 7'd0,  5'd1,  5'd0,  5'd0,  32'h0000_0800, 32'h8000_0093, 1'b1};
    v[7]  = '{BRANCH,          SUB_NONE,      7'h63, 3'd0, 7'd0,  5'd0,  5'd0,  5'd0,  32'd3,         32'h0000_0163, 1'b1};
    v[8]  = '{UPPER,           SUB_NONE,      7'h37, 3'd0, 7'd0,  5'd5,  5'd0,  5'd0,  32'h1234_5001, 32'h1234_52B7, 1'b1};
    v[9]  = '{JUMP,            JUMP_LINK,     7'h6F, 3'd0, 7'd0,  5'd1,  5'd0,  5'd0,  32'h0000_0801, 32'h0010_00EF, 1'b1};
    v[10] = '{BRANCH,          SUB_NONE,      7'h63, 3'd1, 7'd0,  5'd9,  5'd1,  5'd2,  32'hFFFF_FFFC, 32'hFE20_9EE3, 1'b0};
    do_reset();
    iReady = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_req(v[i].t, v[i].s, v[i].opc, v[i].f3, v[i].f7, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      wait_accept(ok);
      iValid = 1'b0;
      if (ok) wait_ovalid(ok);
      n_vec++;
      if (!ok || oInstruction !== v[i].exp || oAddr !== 32'(i * 4) || oError !== (v[i].err & CHK)) begin
        n_err++;
        $display("FAIL fmt_vec%0d: ok=%b word=%h addr=%h err=%b, want %h/%h/%b",
                 i, ok, oInstruction, oAddr, oError, v[i].exp, 32'(i * 4), v[i].err & CHK);
      end
      @(negedge iClk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    do_reset();
    iReady = 1'b1;
    set_req(BRANCH, SUB_NONE, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    wait_accept(ok1);
    set_req(JUMP, JUMP_LINK, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    wait_accept(ok2);
    iValid = 1'b0;
    n_vec++;
    if (!ok1 || !ok2 || oValid !== 1'b1 || oInstruction !== 32'h0020_8463 || oAddr !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_beq: acc=%b%b oValid=%b word=%h addr=%h, want 11/1/00208463/0",
               ok1, ok2, oValid, oInstruction, oAddr);
    end
    @(negedge iClk);
    n_vec++;
    if (oValid !== 1'b1 || oInstruction !== 32'h0010_00EF || oAddr !== 32'h4) begin
      n_err++;
      $display("FAIL b2b_jal: oValid=%b word=%h addr=%h, want 1/001000ef/4",
               oValid, oInstruction, oAddr);
    end
    @(negedge iClk);
  endtask

  task automatic test_stall();
    bit ok1, ok2;
    logic [31:0] w [3];
    w[0] = 32'h0010_0093; w[1] = 32'h0020_0113; w[2] = 32'h0030_0193;
    do_reset();
    iReady = 1'b0;
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    wait_accept(ok1);
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    wait_accept(ok2);
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
    #1;
    n_vec++;
    if (!ok1 || !ok2 || oReady !== 1'b0) begin
      n_err++;
      $display("FAIL stall_ready: acc=%b%b oReady=%b, want 11/0", ok1, ok2, oReady);
    end
    repeat (3) @(negedge iClk);
    n_vec++;
    if (oValid !== 1'b1 || oInstruction !== w[0] || oAddr !== 32'h0 || oReady !== 1'b0) begin
      n_err++;
      $display("FAIL stall_hold: oValid=%b word=%h addr=%h oReady=%b, want 1/%h/0/0",
               oValid, oInstruction, oAddr, oReady, w[0]);
    end
    iReady = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      n_vec++;
      if (oValid !== 1'b1 || oInstruction !== w[i] || oAddr !== 32'(i * 4)) begin
        n_err++;
        $display("FAIL stall_release%0d: oValid=%b word=%h addr=%h, want 1/%h/%h",
                 i, oValid, oInstruction, oAddr, w[i], 32'(i * 4));
      end
      @(negedge iClk);
    end
    n_vec++;
    if (oValid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain: oValid=%b, want 0", oValid);
    end
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    iReady = 1'b1;
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4);
    wait_accept(ok);
    iValid = 1'b0;
    wait_ovalid(ok);
    @(negedge iClk);
    iReady = 1'b0;
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5);
    wait_accept(ok);
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd6);
    wait_accept(ok);
    n_vec++;
    if (oValid !== 1'b1 || oAddr !== 32'h4) begin
      n_err++;
      $display("FAIL flush_pre: oValid=%b addr=%h, want 1/4", oValid, oAddr);
    end
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd7);
    iReady = 1'b1; iFlush = 1'b1;
    @(negedge iClk);
    iFlush = 1'b0; iValid = 1'b0;
    n_vec++;
    if (oValid !== 1'b0 || oAddr !== 32'h0) begin
      n_err++;
      $display("FAIL flush_clear: oValid=%b addr=%h, want 0/0", oValid, oAddr);
    end
    repeat (3) @(negedge iClk);
    n_vec++;
    if (oValid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_discard: oValid=%b, want 0", oValid);
    end
    set_req(IMM_COMPUTATION, SUB_NONE, 7'h13, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'd8);
    wait_accept(ok);
    iValid = 1'b0;
    if (ok) wait_ovalid(ok);
    n_vec++;
    if (!ok || oInstruction !== 32'h0080_0413 || oAddr !== 32'h0) begin
      n_err++;
      $display("FAIL flush_next: ok=%b word=%h addr=%h, want 1/00800413/0", ok, oInstruction, oAddr);
    end
    @(negedge iClk);
  endtask

  task automatic test_random_roundtrip();
    localparam int N = 10000;
    rec_t q[$];
    rec_t cur, r;
    int sent = 0, got = 0, cyc = 0;
    bit pend = 1'b0;
    logic [31:0] v, d;
    int k;
    do_reset();
    while (got < N && cyc < 60000) begin
      iReady = ($urandom_range(0, 3) != 0);
      if (!pend && sent < N) begin
        v = $urandom;
        k = $urandom_range(0, 7);
        cur.s = SUB_NONE;
        case (k)
          0: begin cur.t = REG_COMPUTATION; cur.opc = 7'h33; cur.imm = 32'h0; end
          1: begin cur.t = IMM_COMPUTATION; cur.opc = 7'h13; cur.imm = {{20{v[11]}}, v[11:0]}; end
          2: begin cur.t = LOAD;   cur.opc = 7'h03; cur.imm = {{20{v[11]}}, v[11:0]}; end
          3: begin cur.t = STORE;  cur.opc = 7'h23; cur.imm = {{20{v[11]}}, v[11:0]}; end
          4: begin cur.t = BRANCH; cur.opc = 7'h63; cur.imm = {{19{v[12]}}, v[12:1], 1'b0}; end
          5: begin cur.t = JUMP; cur.s = JUMP_LINK; cur.opc = 7'h6F; cur.imm = {{11{v[20]}}, v[20:1], 1'b0}; end
          6: begin cur.t = JUMP; cur.s = JUMP_LINK_REG; cur.opc = 7'h67; cur.imm = {{20{v[11]}}, v[11:0]}; end
          default: begin cur.t = UPPER; cur.opc = 7'h37; cur.imm = {v[31:12], 12'b0}; end
        endcase
        cur.addr = 32'(sent * 4);
        set_req(cur.t, cur.s, cur.opc, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), (k == 0) ? $urandom : cur.imm);
        pend = 1'b1;
      end
      #1;
      if (oValid && iReady) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: word=%h addr=%h with nothing outstanding", oInstruction, oAddr);
        end else begin
          r = q.pop_front();
          d = dec_imm(r.t, r.s, oInstruction);
          if (d !== r.imm || oInstruction[6:0] !== r.opc || oAddr !== r.addr || oError !== 1'b0) begin
            n_err++;
            $display("FAIL rand_word%0d: imm=%h opc=%h addr=%h err=%b, want %h/%h/%h/0",
                     got, d, oInstruction[6:0], oAddr, oError, r.imm, r.opc, r.addr);
          end
        end
        got++;
      end
      if (iValid && oReady) begin
        q.push_back(cur);
        sent++;
        pend = 1'b0;
      end
      @(negedge iClk);
      if (!pend) iValid = 1'b0;
      cyc++;
    end
    iValid = 1'b0;
    n_vec++;
    if (got != N) begin
      n_err++;
      $display("FAIL rand_count: received %0d words, want %0d", got, N);
    end
  endtask

  initial begin
    test_reset();
    test_addi_latency();
    test_formats();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random_roundtrip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
